// File: rtl/result_pipe_tracker_pkg.sv
// Shared types and constants for the result pipe tracker: widths, stage count
// and the packed per-stage entry.
package result_pipe_tracker_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_W      = 3;
    localparam int NUM_STAGES = 4;

    typedef struct packed {
        logic              write;
        logic [NUM_W-1:0]  num;
        logic [DATA_W-1:0] data;
        logic              pending;
    } stage_entry_t;

    // First writer of src, youngest stage first; returns whether it still awaits load data.
    function automatic logic pending_dep(input stage_entry_t [NUM_STAGES-1:0] st,
                                         input logic [NUM_W-1:0] src);
        logic found;
        logic dep;
        found = 1'b0;
        dep   = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (!found && st[k].write && (st[k].num == src)) begin
                found = 1'b1;
                dep   = st[k].pending;
            end else begin
                found = found;
            end
        end
        return dep;
    endfunction

endpackage

// File: rtl/result_pipe_tracker_stage_reg.sv
// One tracker stage: holds or shifts in an entry, optionally clears its write,
// and accepts a late load fill on top of whatever it moves to this cycle.
module result_stage_reg
    import result_pipe_tracker_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic              fill_i,
    input  stage_entry_t      shift_entry_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              pend_next_o,
    output stage_entry_t      entry_o
);

    stage_entry_t entry_q;
    stage_entry_t moved_s;
    stage_entry_t entry_d;

    // Entry after shift/hold and clear, before any fill.
    always_comb begin
        moved_s         = shift_i ? shift_entry_i : entry_q;
        moved_s.write   = moved_s.write & ~clear_i;
        moved_s.pending = moved_s.pending & ~clear_i;
    end

    assign pend_next_o = moved_s.pending;

    // A fill replaces the data and resolves the pending load.
    always_comb begin
        entry_d = moved_s;
        if (fill_i) begin
            entry_d.data    = fill_data_i;
            entry_d.pending = 1'b0;
        end else begin
            entry_d = moved_s;
        end
    end

    // Stage state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/result_pipe_tracker.sv
// Tracks in-flight results through stages t-1..t-4 for operand forwarding.
// Optional load-use hazard scan enabled by defining RESULT_TRACKER_HAZARD_EN.
module result_pipe_tracker
    import result_pipe_tracker_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              issue_valid_in,
    input  logic              issue_write_in,
    input  logic [NUM_W-1:0]  issue_num_in,
    input  logic [DATA_W-1:0] issue_data_in,
    input  logic              issue_is_load_in,
    output logic              issue_ready_out,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              load_data_valid_in,
    input  logic [DATA_W-1:0] load_data_in,
    input  logic [NUM_W-1:0]  src_a_num_in,
    input  logic [NUM_W-1:0]  src_b_num_in,
    output logic              hazard_stall_out,
    output logic [DATA_W-1:0] data_m1_out,
    output logic [DATA_W-1:0] data_m2_out,
    output logic [DATA_W-1:0] data_m3_out,
    output logic [DATA_W-1:0] data_m4_out,
    output logic [NUM_W-1:0]  num_m1_out,
    output logic [NUM_W-1:0]  num_m2_out,
    output logic [NUM_W-1:0]  num_m3_out,
    output logic [NUM_W-1:0]  num_m4_out,
    output logic              m1_write_out,
    output logic              m2_write_out,
    output logic              m3_write_out,
    output logic              m4_write_out,
    output logic              rf_we_out,
    output logic [NUM_W-1:0]  rf_num_out,
    output logic [DATA_W-1:0] rf_data_out
);

    stage_entry_t [NUM_STAGES-1:0] cur_s;
    stage_entry_t [NUM_STAGES-1:0] shift_in_s;
    logic         [NUM_STAGES-1:0] pend_next_s;
    logic         [NUM_STAGES-1:0] fill_sel_s;
    logic         [NUM_STAGES-1:0] clear_s;
    logic                          advance_s;

    // An unfilled load at t-4 blocks the whole pipe until its data arrives.
    assign advance_s = !stall_in && !(cur_s[NUM_STAGES-1].write && cur_s[NUM_STAGES-1].pending);

    // Entries presented to each stage on advance; a flush squashes the issue and old t-1.
    always_comb begin
        shift_in_s[0].write   = issue_valid_in && issue_write_in && !flush_in;
        shift_in_s[0].num     = issue_num_in;
        shift_in_s[0].pending = issue_is_load_in && shift_in_s[0].write;
        shift_in_s[0].data    = shift_in_s[0].pending ? {DATA_W{1'b0}} : issue_data_in;
        shift_in_s[1]         = cur_s[0];
        shift_in_s[1].write   = cur_s[0].write & ~flush_in;
        shift_in_s[1].pending = cur_s[0].pending & ~flush_in;
        shift_in_s[2]         = cur_s[1];
        shift_in_s[3]         = cur_s[2];
    end

    assign clear_s = {3'b000, flush_in && !advance_s};

    // Fill goes to the oldest stage that is still pending after this cycle's move.
    always_comb begin
        fill_sel_s = 4'b0000;
        if (load_data_valid_in) begin
            if (pend_next_s[3]) begin
                fill_sel_s = 4'b1000;
            end else if (pend_next_s[2]) begin
                fill_sel_s = 4'b0100;
            end else if (pend_next_s[1]) begin
                fill_sel_s = 4'b0010;
            end else if (pend_next_s[0]) begin
                fill_sel_s = 4'b0001;
            end else begin
                fill_sel_s = 4'b0000;
            end
        end else begin
            fill_sel_s = 4'b0000;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        result_stage_reg u_stage (
            .clk_i         (clk_in),
            .rst_n_i       (rst_n_in),
            .shift_i       (advance_s),
            .clear_i       (clear_s[k]),
            .fill_i        (fill_sel_s[k]),
            .shift_entry_i (shift_in_s[k]),
            .fill_data_i   (load_data_in),
            .pend_next_o   (pend_next_s[k]),
            .entry_o       (cur_s[k])
        );
    end

    assign issue_ready_out = advance_s;

    assign data_m1_out  = cur_s[0].data;
    assign data_m2_out  = cur_s[1].data;
    assign data_m3_out  = cur_s[2].data;
    assign data_m4_out  = cur_s[3].data;
    assign num_m1_out   = cur_s[0].num;
    assign num_m2_out   = cur_s[1].num;
    assign num_m3_out   = cur_s[2].num;
    assign num_m4_out   = cur_s[3].num;
    assign m1_write_out = cur_s[0].write;
    assign m2_write_out = cur_s[1].write;
    assign m3_write_out = cur_s[2].write;
    assign m4_write_out = cur_s[3].write;

    assign rf_we_out   = advance_s && cur_s[3].write && !cur_s[3].pending;
    assign rf_num_out  = cur_s[3].num;
    assign rf_data_out = cur_s[3].data;

`ifdef RESULT_TRACKER_HAZARD_EN
    assign hazard_stall_out = pending_dep(cur_s, src_a_num_in) || pending_dep(cur_s, src_b_num_in);
`else
    logic unused_src_s;
    assign unused_src_s     = ^{src_a_num_in, src_b_num_in};
    assign hazard_stall_out = 1'b0;
`endif

endmodule

// File: tb/tb_result_pipe_tracker.sv
// Self-checking bench for result_pipe_tracker: directed scenarios plus random
// traffic, all compared against an in-bench model of the stage rules.
module tb_result_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, iw, ild, stl, fl, ldv;
    logic [2:0]  inum, sa, sb;
    logic [15:0] idata, ldd;

    logic        ready_o, hz_o, rfwe_o;
    logic [2:0]  rfnum_o, n1, n2, n3, n4;
    logic [15:0] rfdata_o, d1, d2, d3, d4;
    logic        w1, w2, w3, w4;

    always #5 clk = ~clk;

    result_pipe_tracker dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .issue_valid_in(iv), .issue_write_in(iw), .issue_num_in(inum),
        .issue_data_in(idata), .issue_is_load_in(ild), .issue_ready_out(ready_o),
        .stall_in(stl), .flush_in(fl), .load_data_valid_in(ldv), .load_data_in(ldd),
        .src_a_num_in(sa), .src_b_num_in(sb), .hazard_stall_out(hz_o),
        .data_m1_out(d1), .data_m2_out(d2), .data_m3_out(d3), .data_m4_out(d4),
        .num_m1_out(n1), .num_m2_out(n2), .num_m3_out(n3), .num_m4_out(n4),
        .m1_write_out(w1), .m2_write_out(w2), .m3_write_out(w3), .m4_write_out(w4),
        .rf_we_out(rfwe_o), .rf_num_out(rfnum_o), .rf_data_out(rfdata_o)
    );

    // model: index 0 is t-1 (youngest), 3 is t-4
    logic        mw[4];
    logic [2:0]  mn[4];
    logic [15:0] md[4];
    logic        mp[4];

    int n_cmp = 0;
    int n_bad = 0;
    logic [101:0] obs_v, exp_v;
    logic        c_ready, c_rfwe, c_hz;
    logic [2:0]  c_rfnum;
    logic [15:0] c_rfdata, c_d3;

    function automatic logic [101:0] dut_vec();
        return {ready_o, hz_o, rfwe_o, rfnum_o, rfdata_o, w4, w3, w2, w1,
                n4, n3, n2, n1, d4, d3, d2, d1};
    endfunction

    function automatic logic model_dep(input logic [2:0] s);
        for (int k = 0; k < 4; k++) begin
            if (mw[k] && mn[k] == s) return mp[k];
        end
        return 1'b0;
    endfunction

    function automatic logic [101:0] model_vec();
        logic adv, hz, we;
        adv = !stl && !(mw[3] && mp[3]);
        we  = adv && mw[3] && !mp[3];
`ifdef RESULT_TRACKER_HAZARD_EN
        hz = model_dep(sa) || model_dep(sb);
`else
        hz = 1'b0;
`endif
        return {adv, hz, we, mn[3], md[3], mw[3], mw[2], mw[1], mw[0],
                mn[3], mn[2], mn[1], mn[0], md[3], md[2], md[1], md[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mw[k] = 1'b0; mn[k] = 3'd0; md[k] = 16'd0; mp[k] = 1'b0;
        end
    endtask

    task automatic model_clock();
        logic adv;
        adv = !stl && !(mw[3] && mp[3]);
        if (adv) begin
            for (int k = 3; k >= 1; k--) begin
                mw[k] = mw[k-1]; mn[k] = mn[k-1]; md[k] = md[k-1]; mp[k] = mp[k-1];
            end
            if (fl) begin mw[1] = 1'b0; mp[1] = 1'b0; end
            mw[0] = iv && iw && !fl;
            mn[0] = inum;
            mp[0] = ild && mw[0];
            md[0] = mp[0] ? 16'd0 : idata;
        end else if (fl) begin
            mw[0] = 1'b0; mp[0] = 1'b0;
        end
        if (ldv) begin
            for (int k = 3; k >= 0; k--) begin
                if (mp[k]) begin
                    md[k] = ldd; mp[k] = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic set_idle();
        iv = 1'b0; iw = 1'b0; inum = 3'd0; idata = 16'd0; ild = 1'b0;
        stl = 1'b0; fl = 1'b0; ldv = 1'b0; ldd = 16'd0; sa = 3'd0; sb = 3'd0;
    endtask

    task automatic set_issue(input logic [2:0] n, input logic [15:0] d, input logic ld);
        iv = 1'b1; iw = 1'b1; inum = n; idata = d; ild = ld;
    endtask

    // one clock: sample DUT and model mid-cycle, then advance both
    task automatic cycle();
        @(negedge clk);
        obs_v = dut_vec();
        exp_v = model_vec();
        c_ready = ready_o; c_rfwe = rfwe_o; c_hz = hz_o;
        c_rfnum = rfnum_o; c_rfdata = rfdata_o; c_d3 = d3;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        logic [101:0] want;
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        want = '0;
        want[101] = 1'b1;
        n_cmp++;
        if (dut_vec() !== want) begin
            n_bad++;
            $display("FAIL reset got=%h exp=%h", dut_vec(), want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            if (i == 0) set_issue(3'd3, 16'h1234, 1'b0);
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL single_write cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (i == 4) begin
                n_cmp++;
                if ({c_rfwe, c_rfnum, c_rfdata} !== {1'b1, 3'd3, 16'h1234}) begin
                    n_bad++;
                    $display("FAIL single_retire got=%h exp=%h", {c_rfwe, c_rfnum, c_rfdata},
                             {1'b1, 3'd3, 16'h1234});
                end
            end
        end
    endtask

    task automatic test_load_hazard();
        logic hz_exp;
`ifdef RESULT_TRACKER_HAZARD_EN
        hz_exp = 1'b1;
`else
        hz_exp = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            set_idle();
            if (i == 0) set_issue(3'd5, 16'hDEAD, 1'b1);
            if (i == 1) begin iv = 1'b1; sa = 3'd5; sb = 3'd1; end
            if (i == 2) begin ldv = 1'b1; ldd = 16'hBEEF; end
            if (i == 3) sa = 3'd5;
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL load_hazard cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (i == 1) begin
                n_cmp++;
                if (c_hz !== hz_exp) begin
                    n_bad++;
                    $display("FAIL hazard_raise got=%b exp=%b", c_hz, hz_exp);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if ({c_hz, c_d3} !== {1'b0, 16'hBEEF}) begin
                    n_bad++;
                    $display("FAIL fill_m3 got=%h exp=%h", {c_hz, c_d3}, {1'b0, 16'hBEEF});
                end
            end
        end
    endtask

    task automatic test_self_stall();
        for (int i = 0; i < 9; i++) begin
            set_idle();
            if (i == 0) set_issue(3'd2, 16'h5555, 1'b1);
            if (i == 6) begin ldv = 1'b1; ldd = 16'h0007; end
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL self_stall cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (i >= 4 && i <= 6) begin
                n_cmp++;
                if ({c_ready, c_rfwe} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL stall_ready cyc%0d got=%b exp=00", i, {c_ready, c_rfwe});
                end
            end
            if (i == 7) begin
                n_cmp++;
                if ({c_ready, c_rfwe, c_rfnum, c_rfdata} !== {1'b1, 1'b1, 3'd2, 16'h0007}) begin
                    n_bad++;
                    $display("FAIL fill_retire got=%h exp=%h", {c_ready, c_rfwe, c_rfnum, c_rfdata},
                             {1'b1, 1'b1, 3'd2, 16'h0007});
                end
            end
        end
    endtask

    task automatic test_flush();
        int retired;
        retired = 0;
        for (int i = 0; i < 10; i++) begin
            set_idle();
            if (i == 0) set_issue(3'd6, 16'h0606, 1'b0);
            if (i == 1) set_issue(3'd7, 16'h0707, 1'b0);
            if (i == 2) set_issue(3'd4, 16'h0404, 1'b0);
            if (i == 3) begin set_issue(3'd1, 16'h0101, 1'b0); fl = 1'b1; end
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL flush cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (c_rfwe) retired++;
        end
        n_cmp++;
        if (retired !== 2) begin
            n_bad++;
            $display("FAIL flush_retire_count got=%0d exp=2", retired);
        end
    endtask

    task automatic test_stall();
        logic [101:0] frozen;
        logic [2:0]   order[$];
        logic [2:0]   want[4];
        want[0] = 3'd1; want[1] = 3'd2; want[2] = 3'd3; want[3] = 3'd5;
        for (int i = 0; i < 12; i++) begin
            set_idle();
            if (i < 4) set_issue(want[i], 16'hA000 + 16'(i), 1'b0);
            if (i >= 4 && i < 7) stl = 1'b1;
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL stall cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (i == 4) frozen = obs_v;
            if (i > 4 && i < 7) begin
                n_cmp++;
                if (obs_v !== frozen || c_rfwe !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_frozen cyc%0d got=%h exp=%h", i, obs_v, frozen);
                end
            end
            if (c_rfwe) order.push_back(c_rfnum);
        end
        n_cmp++;
        if (order.size() != 4 || order[0] !== want[0] || order[1] !== want[1] ||
            order[2] !== want[2] || order[3] !== want[3]) begin
            n_bad++;
            $display("FAIL stall_order got_count=%0d exp_count=4", order.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            iv = ($urandom_range(0, 3) != 0);
            iw = ($urandom_range(0, 4) != 0);
            inum = 3'($urandom_range(0, 7));
            idata = 16'($urandom);
            ild = ($urandom_range(0, 2) == 0);
            stl = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 9) == 0);
            ldv = ($urandom_range(0, 2) == 0);
            ldd = 16'($urandom);
            sa = 3'($urandom_range(0, 7));
            sb = 3'($urandom_range(0, 7));
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [101:0] want;
        for (int i = 0; i < 4; i++) begin
            set_idle();
            set_issue(3'(i + 1), 16'hFFFF, 1'b1);
            cycle();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_bad++;
                $display("FAIL reset_fill cyc%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        want = '0;
        want[101] = 1'b1;
        n_cmp++;
        if (dut_vec() !== want) begin
            n_bad++;
            $display("FAIL reset_midflight got=%h exp=%h", dut_vec(), want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL post_reset got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_load_hazard();
        test_self_stall();
        test_flush();
        test_stall();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
